riscv_multicycle_controller: RTL and testbench

Control FSM for the multi-cycle RV32I datapath. It consumes op/func3/func7 decoded from the instruction register and drives every datapath strobe and mux select: PC/IR/register/memory writes, address, ALU-operand and result selects, ALU operation, immediate format and branch-condition select. Subset: R/I ALU ops, lw, sw, beq/bne/blt/bge, jal, jalr, lui. Unsupported encodings drive a sticky trap.

---
 rtl/riscv_ctrl_pkg.sv | 102 ++++++++++
 rtl/riscv_multicycle_controller_if.sv | 37 +++
 rtl/riscv_alu_decoder.sv | 27 ++
 rtl/riscv_multicycle_controller.sv | 167 ++++++++++++++++
 tb/tb_riscv_multicycle_controller.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/riscv_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle RV32I control FSM and its ALU decoder.
package riscv_ctrl_pkg;

  typedef enum logic [3:0] {
    S_RST      = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEMADR   = 4'd3,
    S_MEMREAD  = 4'd4,
    S_MEMWB    = 4'd5,
    S_MEMWRITE = 4'd6,
    S_EXECR    = 4'd7,
    S_EXECI    = 4'd8,
    S_ALUWB    = 4'd9,
    S_BRANCH   = 4'd10,
    S_JAL      = 4'd11,
    S_JALR1    = 4'd12,
    S_JALR2    = 4'd13,
    S_LUI      = 4'd14,
    S_TRAP     = 4'd15
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [2:0] F3_WORD = 3'b010;
  localparam logic [2:0] F3_JALR = 3'b000;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_AND  = 3'b010;
  localparam logic [2:0] ALU_OR   = 3'b011;
  localparam logic [2:0] ALU_XOR  = 3'b100;
  localparam logic [2:0] ALU_SLT  = 3'b101;
  localparam logic [2:0] ALU_SLTU = 3'b110;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  localparam logic [1:0] RES_ALUOUT    = 2'd0;
  localparam logic [1:0] RES_MDR       = 2'd1;
  localparam logic [1:0] RES_ALURESULT = 2'd2;
  localparam logic [1:0] RES_IMMEXT    = 2'd3;

  localparam logic [1:0] SRCA_PC    = 2'd0;
  localparam logic [1:0] SRCA_OLDPC = 2'd1;
  localparam logic [1:0] SRCA_REG   = 2'd2;

  localparam logic [1:0] SRCB_REG  = 2'd0;
  localparam logic [1:0] SRCB_IMM  = 2'd1;
  localparam logic [1:0] SRCB_FOUR = 2'd2;

  localparam logic [1:0] BSEL_ZERO  = 2'd0;
  localparam logic [1:0] BSEL_NZERO = 2'd1;
  localparam logic [1:0] BSEL_NEG   = 2'd2;
  localparam logic [1:0] BSEL_NNEG  = 2'd3;

  typedef struct packed {
    logic       pc_write;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic       branch;
    logic       illegal;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] bsel;
    logic [2:0] alu_control;
    logic [2:0] imm_src;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '0;

  function automatic logic branch_legal(input logic [2:0] func3);
    return (func3 == 3'b000) || (func3 == 3'b001) ||
           (func3 == 3'b100) || (func3 == 3'b101);
  endfunction

  // beq/bne test the zero flag, blt/bge only the sign of the difference.
  function automatic logic [1:0] bsel_of(input logic [2:0] func3);
    logic [1:0] sel;
    case (func3)
      3'b001:  sel = BSEL_NZERO;
      3'b100:  sel = BSEL_NEG;
      3'b101:  sel = BSEL_NNEG;
      default: sel = BSEL_ZERO;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/riscv_multicycle_controller_if.sv
// Decoded-instruction inputs and datapath control outputs of the multi-cycle controller.
interface riscv_multicycle_controller_if;

  logic [6:0] op;
  logic [2:0] func3;
  logic       func7;

  logic       pc_write;
  logic       adr_src;
  logic       mem_write;
  logic       ir_write;
  logic       reg_write;
  logic       branch;
  logic [1:0] result_src;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] bsel;
  logic [2:0] alu_control;
  logic [2:0] imm_src;
  logic       illegal;
  logic [3:0] state_o;

  modport master (
    input  op, func3, func7,
    output pc_write, adr_src, mem_write, ir_write, reg_write, branch,
           result_src, alu_src_a, alu_src_b, bsel, alu_control, imm_src,
           illegal, state_o
  );

  modport slave (
    output op, func3, func7,
    input  pc_write, adr_src, mem_write, ir_write, reg_write, branch,
           result_src, alu_src_a, alu_src_b, bsel, alu_control, imm_src,
           illegal, state_o
  );

endinterface

// File: rtl/riscv_alu_decoder.sv
// Maps func3/func7 of R- and I-type ALU instructions to an ALU operation and a legality flag.
module riscv_alu_decoder
  import riscv_ctrl_pkg::*;
(
  input  logic [2:0] func3,
  input  logic       func7,
  input  logic       is_rtype,
  output logic [2:0] alu_control,
  output logic       legal
);

  // Shifts (001/101) are outside the supported subset; func7 only selects SUB for R-type.
  always_comb begin
    alu_control = ALU_ADD;
    legal       = 1'b1;
    case (func3)
      3'b000:  alu_control = (is_rtype && func7) ? ALU_SUB : ALU_ADD;
      3'b111:  alu_control = ALU_AND;
      3'b110:  alu_control = ALU_OR;
      3'b100:  alu_control = ALU_XOR;
      3'b010:  alu_control = ALU_SLT;
      3'b011:  alu_control = ALU_SLTU;
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/riscv_multicycle_controller.sv
// Moore control FSM for the multi-cycle RV32I datapath (ALU ops, lw/sw, branches, jal/jalr, lui).
module riscv_multicycle_controller
  import riscv_ctrl_pkg::*;
#(
  parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  riscv_multicycle_controller_if.master  bus
);

  localparam state_t ILLEGAL_NEXT = TRAP_ON_ILLEGAL ? S_TRAP : S_FETCH;

  state_t     state_reg;
  state_t     state_next;
  ctrl_t      ctrl;
  logic [2:0] alu_control_dec;
  logic       func_legal;

  riscv_alu_decoder u_alu_dec (
    .func3       (bus.func3),
    .func7       (bus.func7),
    .is_rtype    (bus.op == OP_RTYPE),
    .alu_control (alu_control_dec),
    .legal       (func_legal)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_RST;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_RST:    state_next = S_FETCH;
      S_FETCH:  state_next = S_DECODE;
      S_DECODE: begin
        case (bus.op)
          OP_LOAD,
          OP_STORE:  state_next = (bus.func3 == F3_WORD) ? S_MEMADR : ILLEGAL_NEXT;
          OP_RTYPE:  state_next = func_legal ? S_EXECR : ILLEGAL_NEXT;
          OP_ITYPE:  state_next = func_legal ? S_EXECI : ILLEGAL_NEXT;
          OP_BRANCH: state_next = branch_legal(bus.func3) ? S_BRANCH : ILLEGAL_NEXT;
          OP_JAL:    state_next = S_JAL;
          OP_JALR:   state_next = (bus.func3 == F3_JALR) ? S_JALR1 : ILLEGAL_NEXT;
          OP_LUI:    state_next = S_LUI;
          default:   state_next = ILLEGAL_NEXT;
        endcase
      end
      S_MEMADR:   state_next = (bus.op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  state_next = S_MEMWB;
      S_MEMWB:    state_next = S_FETCH;
      S_MEMWRITE: state_next = S_FETCH;
      S_EXECR:    state_next = S_ALUWB;
      S_EXECI:    state_next = S_ALUWB;
      S_ALUWB:    state_next = S_FETCH;
      S_BRANCH:   state_next = S_FETCH;
      S_JAL:      state_next = S_ALUWB;
      S_JALR1:    state_next = S_JALR2;
      S_JALR2:    state_next = S_ALUWB;
      S_LUI:      state_next = S_FETCH;
      S_TRAP:     state_next = S_TRAP;
      default:    state_next = S_RST;
    endcase
  end

  always_comb begin
    ctrl = CTRL_IDLE;
    case (state_reg)
      S_FETCH: begin
        ctrl.adr_src    = 1'b0;
        ctrl.ir_write   = 1'b1;
        ctrl.alu_src_a  = SRCA_PC;
        ctrl.alu_src_b  = SRCB_FOUR;
        ctrl.result_src = RES_ALURESULT;
        ctrl.pc_write   = 1'b1;
      end
      // Branch/jump target OldPC + imm is precomputed here into ALUOut.
      S_DECODE: begin
        ctrl.alu_src_a = SRCA_OLDPC;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.imm_src   = (bus.op == OP_JAL) ? IMM_J : IMM_B;
      end
      S_MEMADR: begin
        ctrl.alu_src_a = SRCA_REG;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.imm_src   = (bus.op == OP_STORE) ? IMM_S : IMM_I;
      end
      S_MEMREAD: begin
        ctrl.adr_src    = 1'b1;
        ctrl.result_src = RES_ALUOUT;
      end
      S_MEMWB: begin
        ctrl.result_src = RES_MDR;
        ctrl.reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        ctrl.adr_src    = 1'b1;
        ctrl.result_src = RES_ALUOUT;
        ctrl.mem_write  = 1'b1;
      end
      S_EXECR: begin
        ctrl.alu_src_a   = SRCA_REG;
        ctrl.alu_src_b   = SRCB_REG;
        ctrl.alu_control = alu_control_dec;
      end
      S_EXECI: begin
        ctrl.alu_src_a   = SRCA_REG;
        ctrl.alu_src_b   = SRCB_IMM;
        ctrl.imm_src     = IMM_I;
        ctrl.alu_control = alu_control_dec;
      end
      S_ALUWB: begin
        ctrl.result_src = RES_ALUOUT;
        ctrl.reg_write  = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a   = SRCA_REG;
        ctrl.alu_src_b   = SRCB_REG;
        ctrl.alu_control = ALU_SUB;
        ctrl.branch      = 1'b1;
        ctrl.result_src  = RES_ALUOUT;
        ctrl.bsel        = bsel_of(bus.func3);
      end
      // Jumps load the target from ALUOut while the ALU forms the link value OldPC + 4.
      S_JAL,
      S_JALR2: begin
        ctrl.alu_src_a  = SRCA_OLDPC;
        ctrl.alu_src_b  = SRCB_FOUR;
        ctrl.result_src = RES_ALUOUT;
        ctrl.pc_write   = 1'b1;
      end
      S_JALR1: begin
        ctrl.alu_src_a = SRCA_REG;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.imm_src   = IMM_I;
      end
      S_LUI: begin
        ctrl.imm_src    = IMM_U;
        ctrl.result_src = RES_IMMEXT;
        ctrl.reg_write  = 1'b1;
      end
      S_TRAP:  ctrl.illegal = 1'b1;
      default: ctrl = CTRL_IDLE;
    endcase
  end

  assign bus.pc_write    = ctrl.pc_write;
  assign bus.adr_src     = ctrl.adr_src;
  assign bus.mem_write   = ctrl.mem_write;
  assign bus.ir_write    = ctrl.ir_write;
  assign bus.reg_write   = ctrl.reg_write;
  assign bus.branch      = ctrl.branch;
  assign bus.result_src  = ctrl.result_src;
  assign bus.alu_src_a   = ctrl.alu_src_a;
  assign bus.alu_src_b   = ctrl.alu_src_b;
  assign bus.bsel        = ctrl.bsel;
  assign bus.alu_control = ctrl.alu_control;
  assign bus.imm_src     = ctrl.imm_src;
  assign bus.illegal     = ctrl.illegal;
  assign bus.state_o     = state_reg;

endmodule

// File: tb/tb_riscv_multicycle_controller.sv
// Randomised instruction stream checked cycle by cycle against a per-instruction micro-op model.
module tb_riscv_multicycle_controller;
  import riscv_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  logic [31:0] exp_q[$];
  bit          exp_trap;

  riscv_multicycle_controller_if bus ();
  riscv_multicycle_controller_if bus0 ();

  riscv_multicycle_controller #(.TRAP_ON_ILLEGAL(1'b1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  riscv_multicycle_controller #(.TRAP_ON_ILLEGAL(1'b0)) dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Packed view: state, pc_write, adr_src, mem_write, ir_write, reg_write, branch,
  // result_src, alu_src_a, alu_src_b, bsel, alu_control, imm_src, illegal.
  function automatic logic [31:0] mk(input int st, input int pcw, input int adr, input int mw,
                                     input int irw, input int rw, input int br, input int rs,
                                     input int a, input int b, input int bs, input int alu,
                                     input int imm, input int ill);
    logic [31:0] w;
    w = '0;
    w[24:21] = st[3:0];
    w[20]    = pcw[0];
    w[19]    = adr[0];
    w[18]    = mw[0];
    w[17]    = irw[0];
    w[16]    = rw[0];
    w[15]    = br[0];
    w[14:13] = rs[1:0];
    w[12:11] = a[1:0];
    w[10:9]  = b[1:0];
    w[8:7]   = bs[1:0];
    w[6:4]   = alu[2:0];
    w[3:1]   = imm[2:0];
    w[0]     = ill[0];
    return w;
  endfunction

  function automatic logic [31:0] obs();
    return mk(int'(bus.state_o), int'(bus.pc_write), int'(bus.adr_src), int'(bus.mem_write),
              int'(bus.ir_write), int'(bus.reg_write), int'(bus.branch), int'(bus.result_src),
              int'(bus.alu_src_a), int'(bus.alu_src_b), int'(bus.bsel), int'(bus.alu_control),
              int'(bus.imm_src), int'(bus.illegal));
  endfunction

  // ALU operation for an R/I instruction, or -1 when func3 is unsupported.
  function automatic int alu_ref(input logic [2:0] f3, input logic f7, input bit rtype);
    case (f3)
      3'd0:    return (rtype && f7) ? 1 : 0;
      3'd7:    return 2;
      3'd6:    return 3;
      3'd4:    return 4;
      3'd2:    return 5;
      3'd3:    return 6;
      default: return -1;
    endcase
  endfunction

  task automatic model_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7);
    int alu;
    int bs;
    bit ok;
    ok = 1'b1;
    exp_q.delete();
    exp_trap = 1'b0;
    exp_q.push_back(mk(S_FETCH, 1, 0, 0, 1, 0, 0, 2, 0, 2, 0, 0, 0, 0));
    exp_q.push_back(mk(S_DECODE, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, (op == 7'b1101111) ? 3 : 2, 0));
    case (op)
      7'b0000011: begin
        if (f3 == 3'b010) begin
          exp_q.push_back(mk(S_MEMADR, 0, 0, 0, 0, 0, 0, 0, 2, 1, 0, 0, 0, 0));
          exp_q.push_back(mk(S_MEMREAD, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
          exp_q.push_back(mk(S_MEMWB, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0));
        end else ok = 1'b0;
      end
      7'b0100011: begin
        if (f3 == 3'b010) begin
          exp_q.push_back(mk(S_MEMADR, 0, 0, 0, 0, 0, 0, 0, 2, 1, 0, 0, 1, 0));
          exp_q.push_back(mk(S_MEMWRITE, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        end else ok = 1'b0;
      end
      7'b0110011: begin
        alu = alu_ref(f3, f7, 1'b1);
        if (alu >= 0) begin
          exp_q.push_back(mk(S_EXECR, 0, 0, 0, 0, 0, 0, 0, 2, 0, 0, alu, 0, 0));
          exp_q.push_back(mk(S_ALUWB, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        end else ok = 1'b0;
      end
      7'b0010011: begin
        alu = alu_ref(f3, f7, 1'b0);
        if (alu >= 0) begin
          exp_q.push_back(mk(S_EXECI, 0, 0, 0, 0, 0, 0, 0, 2, 1, 0, alu, 0, 0));
          exp_q.push_back(mk(S_ALUWB, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        end else ok = 1'b0;
      end
      7'b1100011: begin
        if (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd4 || f3 == 3'd5) begin
          bs = (f3 == 3'd0) ? 0 : (f3 == 3'd1) ? 1 : (f3 == 3'd4) ? 2 : 3;
          exp_q.push_back(mk(S_BRANCH, 0, 0, 0, 0, 0, 1, 0, 2, 0, bs, 1, 0, 0));
        end else ok = 1'b0;
      end
      7'b1101111: begin
        exp_q.push_back(mk(S_JAL, 1, 0, 0, 0, 0, 0, 0, 1, 2, 0, 0, 0, 0));
        exp_q.push_back(mk(S_ALUWB, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
      end
      7'b1100111: begin
        if (f3 == 3'd0) begin
          exp_q.push_back(mk(S_JALR1, 0, 0, 0, 0, 0, 0, 0, 2, 1, 0, 0, 0, 0));
          exp_q.push_back(mk(S_JALR2, 1, 0, 0, 0, 0, 0, 0, 1, 2, 0, 0, 0, 0));
          exp_q.push_back(mk(S_ALUWB, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        end else ok = 1'b0;
      end
      7'b0110111: exp_q.push_back(mk(S_LUI, 0, 0, 0, 0, 1, 0, 3, 0, 0, 0, 0, 4, 0));
      default:    ok = 1'b0;
    endcase
    if (!ok) begin
      exp_q.push_back(mk(S_TRAP, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
      exp_trap = 1'b1;
    end
  endtask

  // Leaves rst_n released at a falling edge; the next rising edge enters FETCH.
  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    check_val("rst_hold", obs(), mk(S_RST, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    rst_n = 1'b1;
  endtask

  // Entered with the DUT due to be in FETCH at the next falling edge.
  task automatic run_instr(input string name, input logic [6:0] op, input logic [2:0] f3,
                           input logic f7);
    model_instr(op, f3, f7);
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      check_val($sformatf("%s_c%0d", name, i), obs(), exp_q[i]);
      if (i == 0) begin
        bus.op    = op;
        bus.func3 = f3;
        bus.func7 = f7;
      end
    end
    $display("instr %s op=%b f3=%b f7=%b cycles=%0d trap=%0d", name, op, f3, f7,
             exp_q.size(), exp_trap);
    if (exp_trap) begin
      for (int k = 0; k < 10; k++) begin
        @(negedge clk);
        bus.op = 7'($urandom);
        check_val($sformatf("%s_sticky%0d", name, k), obs(),
                  mk(S_TRAP, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
      end
      do_reset();
    end
  endtask

  task automatic measure_cpi(input string name, input logic [6:0] op, input logic [2:0] f3,
                             input logic f7, input int exp_cycles);
    int n;
    do_reset();
    @(negedge clk);
    bus.op    = op;
    bus.func3 = f3;
    bus.func7 = f7;
    n = 1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.state_o == S_FETCH) break;
      n++;
    end
    check_val(name, 32'(n), 32'(exp_cycles));
    $display("cpi %s cycles=%0d", name, n);
  endtask

  initial begin
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        f7;
    logic [3:0]  exp_st;
    logic [31:0] ops_tbl [8];
    bus.op = '0;  bus.func3 = '0;  bus.func7 = 1'b0;
    bus0.op = '0; bus0.func3 = '0; bus0.func7 = 1'b0;
    ops_tbl = '{32'h03, 32'h23, 32'h33, 32'h13, 32'h63, 32'h6F, 32'h67, 32'h37};
    #12;
    do_reset();

    run_instr("sub",  7'b0110011, 3'b000, 1'b1);
    run_instr("add",  7'b0110011, 3'b000, 1'b0);
    run_instr("addi", 7'b0010011, 3'b000, 1'b1);
    run_instr("lw",   7'b0000011, 3'b010, 1'b0);
    run_instr("sw",   7'b0100011, 3'b010, 1'b0);
    run_instr("beq",  7'b1100011, 3'b000, 1'b0);
    run_instr("bne",  7'b1100011, 3'b001, 1'b0);
    run_instr("blt",  7'b1100011, 3'b100, 1'b0);
    run_instr("bge",  7'b1100011, 3'b101, 1'b0);
    run_instr("jal",  7'b1101111, 3'b011, 1'b0);
    run_instr("jalr", 7'b1100111, 3'b000, 1'b0);
    run_instr("lui",  7'b0110111, 3'b101, 1'b0);
    run_instr("bill", 7'b1100011, 3'b010, 1'b0);

    // Asynchronous reset in the middle of DECODE of a load.
    @(negedge clk);
    bus.op = 7'b0000011; bus.func3 = 3'b010; bus.func7 = 1'b0;
    @(negedge clk);
    check_val("pre_rst_decode", 32'(bus.state_o), 32'(S_DECODE));
    #2 rst_n = 1'b0;
    #1 check_val("rst_async", obs(), mk(S_RST, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    check_val("rst_held", obs(), mk(S_RST, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    rst_n = 1'b1;
    @(posedge clk);
    #1 check_val("rst_release", obs(), mk(S_FETCH, 1, 0, 0, 1, 0, 0, 2, 0, 2, 0, 0, 0, 0));
    run_instr("after_rst", 7'b0110011, 3'b111, 1'b0);

    // Illegal opcode with trapping disabled behaves as a NOP.
    bus0.op = 7'b1111111;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      exp_st = (i % 2 == 0) ? S_FETCH : S_DECODE;
      check_val($sformatf("nop_c%0d", i), {27'd0, bus0.state_o, bus0.illegal},
                {27'd0, exp_st, 1'b0});
    end
    bus0.op = '0;
    do_reset();

    for (int n = 0; n < 150; n++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4, 5, 6, 7: op = 7'(ops_tbl[$urandom_range(0, 7)]);
        8:       op = 7'($urandom);
        default: op = {5'($urandom), 2'b11};
      endcase
      f3 = ($urandom_range(0, 3) == 0) ? 3'($urandom) :
           (op == 7'b0000011 || op == 7'b0100011) ? 3'b010 :
           (op == 7'b1100111) ? 3'b000 : 3'($urandom);
      f7 = (f3 == 3'b000) ? 1'($urandom) : 1'b0;
      run_instr($sformatf("rnd%0d", n), op, f3, f7);
    end

    measure_cpi("cpi_r",    7'b0110011, 3'b000, 1'b1, 4);
    measure_cpi("cpi_i",    7'b0010011, 3'b110, 1'b0, 4);
    measure_cpi("cpi_sw",   7'b0100011, 3'b010, 1'b0, 4);
    measure_cpi("cpi_jal",  7'b1101111, 3'b000, 1'b0, 4);
    measure_cpi("cpi_lw",   7'b0000011, 3'b010, 1'b0, 5);
    measure_cpi("cpi_jalr", 7'b1100111, 3'b000, 1'b0, 5);
    measure_cpi("cpi_br",   7'b1100011, 3'b001, 1'b0, 3);
    measure_cpi("cpi_lui",  7'b0110111, 3'b000, 1'b0, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
